// File: rtl/calc1_port_scheduler_if.sv
// calc1_port_scheduler_if: four requester ports (index 0 = port1) plus the shared-engine handshake; slave = scheduler side, master = requesters/engine side
interface calc1_port_scheduler_if #(parameter int DATA_W = 32);
  logic [3:0][3:0]        req_cmd_in;
  logic [3:0][DATA_W-1:0] req_data_in;
  logic [3:0][1:0]        out_resp;
  logic [3:0][DATA_W-1:0] out_data;
  logic                   eng_valid;
  logic [3:0]             eng_cmd;
  logic [DATA_W-1:0]      eng_op1;
  logic [DATA_W-1:0]      eng_op2;
  logic                   eng_ready;
  logic                   eng_done;
  logic [1:0]             eng_resp;
  logic [DATA_W-1:0]      eng_result;
  modport slave (
    input  req_cmd_in, req_data_in, eng_ready, eng_done, eng_resp, eng_result,
    output out_resp, out_data, eng_valid, eng_cmd, eng_op1, eng_op2
  );
  modport master (
    output req_cmd_in, req_data_in, eng_ready, eng_done, eng_resp, eng_result,
    input  out_resp, out_data, eng_valid, eng_cmd, eng_op1, eng_op2
  );
endinterface

// File: rtl/calc1_port_scheduler.sv
// calc1_port_scheduler: round-robin sharing of one calc engine by four two-cycle command ports; ports c_clk, reset_n (async low), bus (requesters in/responses out, engine valid/ready out, done/resp/result in)
module calc1_port_scheduler #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  c_clk,
  input  logic                  reset_n,
  calc1_port_scheduler_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, CAPT, PEND, BUSY} port_t;
  typedef enum logic [1:0] {A_IDLE, ISSUE, WAIT, RETURN} arb_t;
  port_t             st [4];
  logic [3:0]        cmd [4];
  logic [DATA_W-1:0] op1 [4];
  logic [DATA_W-1:0] op2 [4];
  arb_t              ast;
  logic [1:0]        ptr, gnt, sel;
  logic              found;
  logic [CW-1:0]     cnt;
  logic [1:0]        rsp;
  logic [DATA_W-1:0] res;
  function automatic logic legal(input logic [3:0] c);
    return c inside {4'd1, 4'd2, 4'd5, 4'd6};
  endfunction
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    for (int k = 3; k >= 0; k--)
      if (st[ptr + 2'(k)] == PEND) begin
        found = 1'b1;
        sel   = ptr + 2'(k);
      end
  end
  always_ff @(posedge c_clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        st[i]  <= IDLE;
        cmd[i] <= '0;
        op1[i] <= '0;
        op2[i] <= '0;
      end
      bus.out_resp  <= '0;
      bus.out_data  <= '0;
      bus.eng_valid <= 1'b0;
      bus.eng_cmd   <= '0;
      bus.eng_op1   <= '0;
      bus.eng_op2   <= '0;
      ast <= A_IDLE;
      ptr <= '0;
      gnt <= '0;
      cnt <= '0;
      rsp <= '0;
      res <= '0;
    end else begin
      bus.out_resp <= '0;
      bus.out_data <= '0;
      for (int i = 0; i < 4; i++)
        case (st[i])
          IDLE:
            if (legal(bus.req_cmd_in[i])) begin
              st[i]  <= CAPT;
              cmd[i] <= bus.req_cmd_in[i];
              op1[i] <= bus.req_data_in[i];
            end else if (bus.req_cmd_in[i] != 4'd0) bus.out_resp[i] <= 2'd2;
          CAPT: begin
            op2[i] <= bus.req_data_in[i];
            st[i]  <= PEND;
          end
          default: ;
        endcase
      case (ast)
        A_IDLE:
          if (found) begin
            gnt           <= sel;
            st[sel]       <= BUSY;
            bus.eng_valid <= 1'b1;
            bus.eng_cmd   <= cmd[sel];
            bus.eng_op1   <= op1[sel];
            bus.eng_op2   <= op2[sel];
            ast           <= ISSUE;
          end
        ISSUE:
          if (bus.eng_ready) begin
            bus.eng_valid <= 1'b0;
            cnt           <= '0;
            ast           <= WAIT;
          end
        WAIT:
          if (bus.eng_done) begin
            rsp <= bus.eng_resp;
            res <= bus.eng_result;
            ast <= RETURN;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp <= 2'd3;
            res <= '0;
            ast <= RETURN;
          end else cnt <= cnt + 1'b1;
        RETURN: begin
          bus.out_resp[gnt] <= rsp;
          bus.out_data[gnt] <= res;
          st[gnt]           <= IDLE;
          ptr               <= gnt + 2'd1;
          ast               <= A_IDLE;
        end
        default: ast <= A_IDLE;
      endcase
    end
endmodule

// File: tb/tb_calc1_port_scheduler.sv
// tb_calc1_port_scheduler: scoreboard bench for the four-port calc scheduler
module tb_calc1_port_scheduler;
  localparam int TIMEOUT = 16;
  typedef struct { int port; logic [1:0] resp; logic [31:0] data; int lat; } exp_t;
  typedef struct { logic [3:0] cmd; logic [31:0] op1; logic [31:0] op2; } eng_t;
  typedef struct { bit drop; logic [1:0] resp; logic [31:0] res; } rsp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_cnt = 0;
  int acc_seen = 0;
  int late_cnt = 0;
  int late_seen = 0;
  exp_t exp_q[$];
  eng_t eng_q[$];
  rsp_t rsp_q[$];
  calc1_port_scheduler_if #(.DATA_W(32)) bus();
  calc1_port_scheduler #(.DATA_W(32), .TIMEOUT(TIMEOUT)) dut (.c_clk(clk), .reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int p, input logic [3:0] c, input logic [31:0] d);
    bus.req_cmd_in[p] = c;
    bus.req_data_in[p] = d;
  endtask
  task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    drive(p, c, a);
    tick();
    drive(p, 4'd0, b);
    tick();
    drive(p, 4'd0, 32'd0);
  endtask
  task automatic expect_cmd(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] r, input logic [31:0] res);
    eng_q.push_back('{c, a, b});
    rsp_q.push_back('{1'b0, r, res});
    exp_q.push_back('{p, r, res, 3});
  endtask
  task automatic expect_drop(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    eng_q.push_back('{c, a, b});
    rsp_q.push_back('{1'b1, 2'd0, 32'd0});
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_cmd_in = '0;
    bus.req_data_in = '0;
    bus.eng_ready = 1'b1;
    repeat (2) tick();
    check("rst_eng", {bus.eng_valid, bus.eng_cmd, bus.eng_op1, bus.eng_op2}, 0);
    check("rst_resp", bus.out_resp, 0);
    check("rst_data", bus.out_data, 0);
    rst_n = 1'b1;
    tick();
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || eng_q.size() != 0); i++) tick();
    repeat (3) tick();
    check("drain_exp", exp_q.size(), 0);
    check("drain_eng", eng_q.size(), 0);
    check("drain_rsp", rsp_q.size(), 0);
  endtask
  initial begin
    rsp_t r;
    bus.eng_done = 1'b0;
    bus.eng_resp = 2'd0;
    bus.eng_result = 32'd0;
    forever begin
      tick();
      bus.eng_done = 1'b0;
      bus.eng_resp = 2'd0;
      bus.eng_result = 32'd0;
      if (acc_cnt != acc_seen) begin
        acc_seen++;
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          if (!r.drop) begin
            bus.eng_done = 1'b1;
            bus.eng_resp = r.resp;
            bus.eng_result = r.res;
          end
        end
      end else if (late_cnt != late_seen) begin
        late_seen++;
        bus.eng_done = 1'b1;
        bus.eng_resp = 2'd1;
        bus.eng_result = 32'hDEAD_BEEF;
      end
    end
  end
  initial begin
    exp_t e;
    eng_t g;
    logic pv_hold, pv_acc;
    logic [3:0] pv_cmd;
    logic [31:0] pv_op1, pv_op2;
    pv_hold = 1'b0;
    pv_acc = 1'b0;
    pv_cmd = '0;
    pv_op1 = '0;
    pv_op2 = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pv_hold = 1'b0;
        pv_acc = 1'b0;
        continue;
      end
      for (int p = 0; p < 4; p++)
        if (bus.out_resp[p] != 2'd0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp port=%0d got resp=%0d data=%0h exp none", p + 1, bus.out_resp[p], bus.out_data[p]);
          end else begin
            e = exp_q.pop_front();
            check("resp_port", p, e.port);
            check("resp_code", bus.out_resp[p], e.resp);
            check("resp_data", bus.out_data[p], e.data);
            if (e.lat != 0) check("resp_latency", cyc - acc_cyc, e.lat);
          end
        end else check("idle_data_zero", bus.out_data[p], 0);
      if (pv_hold) check("eng_hold", {bus.eng_valid, bus.eng_cmd, bus.eng_op1, bus.eng_op2}, {1'b1, pv_cmd, pv_op1, pv_op2});
      if (pv_acc) check("eng_valid_drop", bus.eng_valid, 0);
      pv_hold = bus.eng_valid && !bus.eng_ready;
      pv_acc = bus.eng_valid && bus.eng_ready;
      pv_cmd = bus.eng_cmd;
      pv_op1 = bus.eng_op1;
      pv_op2 = bus.eng_op2;
      if (pv_acc) begin
        acc_cyc = cyc;
        acc_cnt++;
        if (eng_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_accept got cmd=%0d op1=%0h op2=%0h exp none", bus.eng_cmd, bus.eng_op1, bus.eng_op2);
        end else begin
          g = eng_q.pop_front();
          check("eng_cmd", {bus.eng_cmd, bus.eng_op1, bus.eng_op2}, {g.cmd, g.op1, g.op2});
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_cmd_in = '0;
    bus.req_data_in = '0;
    bus.eng_ready = 1'b1;
    do_reset();
    expect_cmd(0, 4'd1, 32'h1, 32'h01FF_FFFF, 2'd1, 32'h0200_0000);
    issue(0, 4'd1, 32'h1, 32'h01FF_FFFF);
    wait_idle();
    do_reset();
    for (int p = 0; p < 4; p++) expect_cmd(p, 4'd1, p + 1, p + 1, 2'd1, 2 * (p + 1));
    for (int p = 0; p < 4; p++) drive(p, 4'd1, p + 1);
    tick();
    for (int p = 0; p < 4; p++) drive(p, 4'd0, p + 1);
    tick();
    for (int p = 0; p < 4; p++) drive(p, 4'd0, 32'd0);
    wait_idle();
    expect_cmd(1, 4'd2, 32'd9, 32'd4, 2'd1, 32'd5);
    expect_cmd(3, 4'd1, 32'h10, 32'h20, 2'd1, 32'h30);
    expect_cmd(0, 4'd6, 32'h80, 32'd3, 2'd1, 32'h10);
    issue(1, 4'd2, 32'd9, 32'd4);
    drive(0, 4'd6, 32'h80);
    drive(3, 4'd1, 32'h10);
    tick();
    drive(0, 4'd0, 32'd3);
    drive(3, 4'd0, 32'h20);
    tick();
    drive(0, 4'd0, 32'd0);
    drive(3, 4'd0, 32'd0);
    wait_idle();
    exp_q.push_back('{2, 2'd2, 32'd0, 0});
    expect_cmd(2, 4'd1, 32'd7, 32'd8, 2'd1, 32'd15);
    drive(2, 4'd3, 32'h55);
    tick();
    issue(2, 4'd1, 32'd7, 32'd8);
    wait_idle();
    bus.eng_ready = 1'b0;
    expect_cmd(0, 4'd2, 32'd100, 32'd1, 2'd1, 32'd99);
    issue(0, 4'd2, 32'd100, 32'd1);
    repeat (6) tick();
    check("valid_while_stalled", bus.eng_valid, 1);
    bus.eng_ready = 1'b1;
    wait_idle();
    expect_drop(4'd1, 32'd1, 32'd2);
    exp_q.push_back('{0, 2'd3, 32'd0, TIMEOUT + 2});
    expect_cmd(1, 4'd1, 32'd3, 32'd4, 2'd1, 32'd7);
    issue(0, 4'd1, 32'd1, 32'd2);
    issue(1, 4'd1, 32'd3, 32'd4);
    wait_idle();
    late_cnt++;
    repeat (5) tick();
    wait_idle();
    expect_drop(4'd1, 32'd4, 32'd5);
    issue(0, 4'd1, 32'd4, 32'd5);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_eng", {bus.eng_valid, bus.eng_cmd, bus.eng_op1, bus.eng_op2}, 0);
    check("async_rst_resp", bus.out_resp, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    expect_cmd(1, 4'd2, 32'd5, 32'd3, 2'd1, 32'd2);
    issue(1, 4'd2, 32'd5, 32'd3);
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
